// File: rtl/rst_seq_ctrl_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, legal
// parameter ranges and a small constant helper used for width sizing.
package rst_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam int NUM_STAGES_MIN  = 2;
    localparam int NUM_STAGES_MAX  = 8;
    localparam int NUM_CH_MIN      = 1;
    localparam int NUM_CH_MAX      = 16;
    localparam int HOLD_CYCLES_MIN = 1;
    localparam int HOLD_CYCLES_MAX = 1024;
    localparam int GAP_CYCLES_MIN  = 1;
    localparam int GAP_CYCLES_MAX  = 256;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_sync.sv
// rst_sync_core: reset synchronizer. Asserts asynchronously with RST low and
// releases synchronously after NUM_STAGES rising CLK edges.
//   CLK        in  clock
//   RST        in  async active-low reset source
//   SYNC_RST_N out synchronized active-low reset
module rst_sync_core #(
    parameter int NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    output logic SYNC_RST_N
);

    logic [NUM_STAGES-1:0] sync_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) sync_q <= '0;
        else      sync_q <= {sync_q[NUM_STAGES-2:0], 1'b1};
    end

    assign SYNC_RST_N = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: reset sequencer. Holds all channels in reset for HOLD_CYCLES
// after the synchronized reset (or a software reset) ends, then releases
// channel 0 upward, one every GAP_CYCLES, and flags RST_DONE one edge after
// the last channel.
//   CLK       in  clock
//   RST       in  async active-low reset source
//   SW_RST    in  synchronous software reset request (active-high)
//   CH_RST_N  out per-channel active-low resets, registered
//   RST_DONE  out all channels released, registered
module rst_seq_ctrl
    import rst_seq_ctrl_pkg::*;
#(
    parameter int NUM_STAGES  = 2,
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SW_RST,
    output logic [NUM_CH-1:0] CH_RST_N,
    output logic              RST_DONE
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam int IDX_W = $clog2(NUM_CH + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_ALL   = IDX_W'(NUM_CH);

    logic sync_rst_n;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [NUM_CH-1:0] ch_q,    ch_d;
    logic              done_q,  done_d;

    rst_sync_core #(
        .NUM_STAGES (NUM_STAGES)
    ) u_sync (
        .CLK        (CLK),
        .RST        (RST),
        .SYNC_RST_N (sync_rst_n)
    );

    // State register: the synchronized reset clears everything asynchronously.
    always_ff @(posedge CLK or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            ch_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ch_q    <= ch_d;
            done_q  <= done_d;
        end
    end

    // Next state. SW_RST has top priority so a coincident release is lost.
    // cnt counts the edges already spent in the current wait; the release
    // happens on the edge where it reaches the last value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ch_d    = ch_q;
        done_d  = done_q;
        if (SW_RST) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            ch_d    = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        ch_d[0] = 1'b1;
                        idx_d   = IDX_W'(1);
                        cnt_d   = '0;
                        state_d = ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (idx_q == IDX_ALL) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (cnt_q == GAP_LAST) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (idx_q == IDX_W'(i)) ch_d[i] = 1'b1;
                        end
                        idx_d = idx_q + 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DONE: ;
                default: state_d = ST_HOLD;
            endcase
        end
    end

    // Outputs come straight from flops; no combinational path from SW_RST.
    always_comb begin
        CH_RST_N = ch_q;
        RST_DONE = done_q;
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
module tb_rst_seq_ctrl;

    localparam int NS   = 2;
    localparam int NCH  = 4;
    localparam int H    = 16;
    localparam int G    = 4;
    localparam int NS2  = 3;
    localparam int NCH2 = 1;
    localparam int H2   = 1;
    localparam int G2   = 4;
    localparam int BIG  = 32'h3fff_0000;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       SW  = 1'b0;
    logic [3:0] ch1;
    logic       done1;
    logic [0:0] ch2;
    logic       done2;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    int r1 = BIG;   // release reference edge: ch[i] high from r+H+i*G on
    int r2 = BIG;

    always #5 CLK = ~CLK;

    rst_seq_ctrl #(
        .NUM_STAGES (NS), .NUM_CH (NCH), .HOLD_CYCLES (H), .GAP_CYCLES (G)
    ) dut (
        .CLK (CLK), .RST (RST), .SW_RST (SW), .CH_RST_N (ch1), .RST_DONE (done1)
    );

    rst_seq_ctrl #(
        .NUM_STAGES (NS2), .NUM_CH (NCH2), .HOLD_CYCLES (H2), .GAP_CYCLES (G2)
    ) dut2 (
        .CLK (CLK), .RST (RST), .SW_RST (SW), .CH_RST_N (ch2), .RST_DONE (done2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
        end
    endtask

    function automatic logic [31:0] mdl_ch(input int n, input int r, input int h,
                                           input int g, input int nch);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < nch; i++)
            if (n >= r + h + i * g) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] mdl_done(input int n, input int r, input int h,
                                             input int g, input int nch);
        return {31'd0, n >= r + h + (nch - 1) * g + 1};
    endfunction

    task automatic cmp_model();
        chk("ch1",   {28'd0, ch1},   mdl_ch(edge_n, r1, H, G, NCH));
        chk("done1", {31'd0, done1}, mdl_done(edge_n, r1, H, G, NCH));
        chk("ch2",   {31'd0, ch2},   mdl_ch(edge_n, r2, H2, G2, NCH2));
        chk("done2", {31'd0, done2}, mdl_done(edge_n, r2, H2, G2, NCH2));
    endtask

    task automatic glitch();
        #1 RST = 1'b0;
        #1;
        chk("glitch_ch1",   {28'd0, ch1},   32'd0);
        chk("glitch_done1", {31'd0, done1}, 32'd0);
        chk("glitch_ch2",   {31'd0, ch2},   32'd0);
        chk("glitch_done2", {31'd0, done2}, 32'd0);
        #1 RST = 1'b1;
        r1 = edge_n + NS;
        r2 = edge_n + NS2;
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_ch1",   {28'd0, ch1},   32'd0);
        chk("rst_done1", {31'd0, done1}, 32'd0);
        chk("rst_ch2",   {31'd0, ch2},   32'd0);
        #1 RST = 1'b1;
        edge_n = 0;
        r1 = NS;
        r2 = NS2;
        for (int c = 0; c < 900; c++) begin
            @(posedge CLK);
            edge_n++;
            // A software reset only counts once the sequencer is out of reset.
            if (SW) begin
                if (edge_n > r1) r1 = edge_n;
                if (edge_n > r2) r2 = edge_n;
            end
            #1;
            SW = (edge_n + 1 == 50) || (edge_n + 1 >= 100 && edge_n + 1 <= 109) ||
                 (edge_n >= 200 && ($urandom % 30) == 0);
            @(negedge CLK);
            cmp_model();
            case (edge_n)
                3:   chk("d2_e3_ch",    {31'd0, ch2},   32'd0);
                4:   begin chk("d2_e4_ch", {31'd0, ch2}, 32'd1);
                           chk("d2_e4_done", {31'd0, done2}, 32'd0); end
                5:   chk("d2_e5_done",  {31'd0, done2}, 32'd1);
                17:  chk("e17_ch",      {28'd0, ch1},   32'h0);
                18:  chk("e18_ch",      {28'd0, ch1},   32'h1);
                26:  chk("e26_ch",      {28'd0, ch1},   32'h7);
                30:  begin chk("e30_ch", {28'd0, ch1}, 32'hf);
                           chk("e30_done", {31'd0, done1}, 32'd0); end
                31:  chk("e31_done",    {31'd0, done1}, 32'd1);
                50:  begin chk("e50_ch", {28'd0, ch1}, 32'h0);
                           chk("e50_done", {31'd0, done1}, 32'd0); end
                66:  chk("e66_ch",      {28'd0, ch1},   32'h1);
                79:  chk("e79_done",    {31'd0, done1}, 32'd1);
                124: chk("e124_ch",     {28'd0, ch1},   32'h0);
                125: chk("e125_ch",     {28'd0, ch1},   32'h1);
                137: chk("e137_done",   {31'd0, done1}, 32'd0);
                138: chk("e138_done",   {31'd0, done1}, 32'd1);
                177: chk("e177_ch",     {28'd0, ch1},   32'h0);
                178: chk("e178_ch",     {28'd0, ch1},   32'h1);
                default: ;
            endcase
            if (edge_n == 160 || (edge_n >= 200 && ($urandom % 120) == 0))
                glitch();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
